neo_sound_latch: RTL and testbench
==================================

NEO_SOUND_LATCH -- requirements
Module: neo_sound_latch

Interface
REQ-001 SHALL have: CLK  in  1  system clock; all state changes on rising edge.
REQ-002 SHALL have: nRESET  in  1  reset, synchronous, active-low.
REQ-003 SHALL have: nSNDWR  in  1  68k write strobe for the sound command register, active-low.
REQ-004 SHALL have: nSNDRD  in  1  68k read strobe for the sound reply register, active-low.
REQ-005 SHALL have: M68K_DATA_H  in  8  68k data bus upper byte (command value).
REQ-006 SHALL have: nSDZ80R  in  1  Z80 command-read strobe from z80ctrl, active-low.
REQ-007 SHALL have: nSDZ80W  in  1  Z80 reply-write strobe from z80ctrl, active-low.
REQ-008 SHALL have: nSDZ80CLR  in  1  Z80 clear strobe from z80ctrl, active-low.
REQ-009 SHALL have: SDD_IN  in  8  Z80 data bus write value.
REQ-010 SHALL have: SDD_OUT  out  8  command value driven to Z80 bus.
REQ-011 SHALL have: SDD_OE  out  1  high while SDD_OUT is valid for the Z80 bus.
REQ-012 SHALL have: M68K_SND_DATA  out  8  reply value driven to 68k.
REQ-013 SHALL have: nNMI_REQ  out  1  Z80 NMI request to z80ctrl, active-low.
REQ-014 SHALL have: CMD_PEND  out  1  command written but not yet read by Z80.
REQ-015 SHALL have: RPL_PEND  out  1  reply written but not yet read by 68k.
REQ-016 SHALL have: OVERRUN  out  1  sticky flag, command overwritten while pending.

Function
REQ-017 All strobes SHALL be registered once; action SHALL occur on the cycle a falling edge (previous 1, current 0) is detected, never on level.
REQ-018 A nSNDWR falling edge SHALL load M68K_DATA_H into CMD and set CMD_PEND and assert nNMI_REQ low, all visible the cycle after detection (latency 1).
REQ-019 A nSNDWR edge while CMD_PEND=1 SHALL overwrite CMD and set OVERRUN.
REQ-020 A nSDZ80R falling edge SHALL clear CMD_PEND and release nNMI_REQ high (latency 1).
REQ-021 SDD_OE SHALL equal the registered inverse of nSDZ80R; SDD_OUT SHALL present CMD continuously.
REQ-022 A nSDZ80W falling edge SHALL load SDD_IN into RPL and set RPL_PEND (latency 1).
REQ-023 A nSNDRD falling edge SHALL clear RPL_PEND; M68K_SND_DATA SHALL present RPL continuously.
REQ-024 A nSDZ80CLR falling edge SHALL clear CMD to 0x00, CMD_PEND, OVERRUN, and release nNMI_REQ.
REQ-025 Simultaneous nSNDWR and nSDZ80R edges: write SHALL win (CMD loaded, CMD_PEND=1, nNMI_REQ=0); the Z80 read SHALL see the old CMD.
REQ-026 Simultaneous nSNDWR and nSDZ80CLR edges: write SHALL win; OVERRUN SHALL be cleared.
REQ-027 Simultaneous nSDZ80W and nSNDRD edges: write SHALL win (RPL_PEND=1).
REQ-028 A strobe held low SHALL produce exactly one action.

Reset
REQ-029 With nRESET=0 at a clock edge, CMD=0x00, RPL=0x00, CMD_PEND=0, RPL_PEND=0, OVERRUN=0, nNMI_REQ=1, SDD_OE=0.
REQ-030 Edge-detect registers SHALL reset to 1 so a strobe already low at reset release is not an edge.
REQ-031 Reset mid-operation SHALL discard pending command/reply with no NMI after release.

Structure
REQ-032 Data width (8), CMD/RPL reset value (0x00) SHALL be constants in package neo_snd_pkg.
REQ-033 Falling-edge detection SHALL be one reusable sub-module neo_edge_fall (instanced per strobe).

Verification
REQ-034 Reset, nSNDWR pulse with 0x5A -> next cycle CMD_PEND=1, nNMI_REQ=0, SDD_OUT=0x5A.
REQ-035 Then nSDZ80R pulse -> SDD_OE=1 during pulse, CMD_PEND=0, nNMI_REQ=1 one cycle after edge.
REQ-036 Two nSNDWR (0x11, 0x22) without Z80 read -> SDD_OUT=0x22, OVERRUN=1; nSDZ80CLR -> OVERRUN=0, SDD_OUT=0x00.
REQ-037 nSDZ80W with SDD_IN=0xA5 -> RPL_PEND=1, M68K_SND_DATA=0xA5; nSNDRD -> RPL_PEND=0, data stays 0xA5.
REQ-038 nSNDWR 0x33 and nSDZ80R edges same cycle -> CMD_PEND=1, nNMI_REQ=0, SDD_OUT=0x33.
REQ-039 nSNDWR held low across nRESET release -> no CMD_PEND; nRESET asserted with CMD_PEND=1 -> all outputs to reset values next cycle.

Source files
------------

// File: rtl/neo_snd_pkg.sv
// neo_snd_pkg: shared widths, reset values and strobe indices for the sound latch.
package neo_snd_pkg;
    localparam int DW = 8;
    localparam logic [DW-1:0] CMD_RST = 8'h00;
    localparam logic [DW-1:0] RPL_RST = 8'h00;
    localparam int N_STROBE = 5;
    localparam int S_WR  = 0;
    localparam int S_RD  = 1;
    localparam int S_ZR  = 2;
    localparam int S_ZW  = 3;
    localparam int S_CLR = 4;
endpackage

// File: rtl/neo_edge_fall.sv
// neo_edge_fall: registers an active-low strobe once and flags its falling edge.
module neo_edge_fall (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe,
    output logic fall
);
    logic level, prev, primed;
    // The first sample after reset seeds both stages so a strobe already low is not an edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level  <= 1'b1;
            prev   <= 1'b1;
            primed <= 1'b0;
        end else begin
            level  <= strobe;
            prev   <= primed ? level : strobe;
            primed <= 1'b1;
        end
    end
    assign fall = prev & ~level;
endmodule

// File: rtl/neo_sound_latch.sv
// neo_sound_latch: 68k<->Z80 sound command/reply mailbox with NMI request and overrun flag.
module neo_sound_latch
    import neo_snd_pkg::*;
(
    input  logic          CLK,
    input  logic          nRESET,
    input  logic          nSNDWR,
    input  logic          nSNDRD,
    input  logic [DW-1:0] M68K_DATA_H,
    input  logic          nSDZ80R,
    input  logic          nSDZ80W,
    input  logic          nSDZ80CLR,
    input  logic [DW-1:0] SDD_IN,
    output logic [DW-1:0] SDD_OUT,
    output logic          SDD_OE,
    output logic [DW-1:0] M68K_SND_DATA,
    output logic          nNMI_REQ,
    output logic          CMD_PEND,
    output logic          RPL_PEND,
    output logic          OVERRUN
);
    logic [N_STROBE-1:0] strb, fall;
    assign strb = {nSDZ80CLR, nSDZ80W, nSDZ80R, nSNDRD, nSNDWR};
    for (genvar g = 0; g < N_STROBE; g++) begin : g_edge
        neo_edge_fall u_edge (.clk(CLK), .rst_n(nRESET), .strobe(strb[g]), .fall(fall[g]));
    end
    // A 68k write always wins; a same-cycle Z80 read consumes the old command, so no overrun.
    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            SDD_OUT       <= CMD_RST;
            M68K_SND_DATA <= RPL_RST;
            CMD_PEND      <= 1'b0;
            RPL_PEND      <= 1'b0;
            OVERRUN       <= 1'b0;
            nNMI_REQ      <= 1'b1;
            SDD_OE        <= 1'b0;
        end else begin
            SDD_OE <= ~nSDZ80R;
            if (fall[S_WR]) begin
                SDD_OUT  <= M68K_DATA_H;
                CMD_PEND <= 1'b1;
                nNMI_REQ <= 1'b0;
                OVERRUN  <= ~fall[S_CLR] & (OVERRUN | (CMD_PEND & ~fall[S_ZR]));
            end else if (fall[S_CLR]) begin
                SDD_OUT  <= CMD_RST;
                CMD_PEND <= 1'b0;
                OVERRUN  <= 1'b0;
                nNMI_REQ <= 1'b1;
            end else if (fall[S_ZR]) begin
                CMD_PEND <= 1'b0;
                nNMI_REQ <= 1'b1;
            end
            if (fall[S_ZW]) begin
                M68K_SND_DATA <= SDD_IN;
                RPL_PEND      <= 1'b1;
            end else if (fall[S_RD]) begin
                RPL_PEND <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_neo_sound_latch.sv
// tb_neo_sound_latch: directed and randomised stimulus checked against an event-level mailbox model.
module tb_neo_sound_latch;
    localparam int WR = 0, RD = 1, ZR = 2, ZW = 3, CLR = 4;
    logic       CLK = 1'b0;
    logic       nRESET = 1'b0;
    logic [4:0] st = 5'h1f;
    logic [7:0] data = 8'h00, sdd_in = 8'h00;
    logic [7:0] SDD_OUT, M68K_SND_DATA;
    logic       SDD_OE, nNMI_REQ, CMD_PEND, RPL_PEND, OVERRUN;
    int n_chk = 0, n_fail = 0;
    logic chk_en = 1'b0;

    neo_sound_latch dut (
        .CLK(CLK), .nRESET(nRESET),
        .nSNDWR(st[WR]), .nSNDRD(st[RD]), .M68K_DATA_H(data),
        .nSDZ80R(st[ZR]), .nSDZ80W(st[ZW]), .nSDZ80CLR(st[CLR]), .SDD_IN(sdd_in),
        .SDD_OUT(SDD_OUT), .SDD_OE(SDD_OE), .M68K_SND_DATA(M68K_SND_DATA),
        .nNMI_REQ(nNMI_REQ), .CMD_PEND(CMD_PEND), .RPL_PEND(RPL_PEND), .OVERRUN(OVERRUN)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Mailbox model: a high->low pair of samples is an event taking effect one edge later.
    logic [7:0] m_cmd = 8'h00, m_rpl = 8'h00;
    logic       m_cp = 1'b0, m_rp = 1'b0, m_ovr = 1'b0, m_oe = 1'b0, primed = 1'b0;
    logic [4:0] prev = 5'h1f, ev = 5'h00;
    always @(posedge CLK) begin
        if (!nRESET) begin
            m_cmd = 8'h00; m_rpl = 8'h00; m_cp = 1'b0; m_rp = 1'b0; m_ovr = 1'b0;
            m_oe = 1'b0; primed = 1'b0; ev = 5'h00;
        end else begin
            if (ev[WR]) begin
                m_ovr = ev[CLR] ? 1'b0 : (m_ovr || (m_cp && !ev[ZR]));
                m_cmd = data;
                m_cp  = 1'b1;
            end else if (ev[CLR]) begin
                m_cmd = 8'h00; m_cp = 1'b0; m_ovr = 1'b0;
            end else if (ev[ZR]) begin
                m_cp = 1'b0;
            end
            if (ev[ZW]) begin
                m_rpl = sdd_in; m_rp = 1'b1;
            end else if (ev[RD]) begin
                m_rp = 1'b0;
            end
            ev     = primed ? (prev & ~st) : 5'h00;
            prev   = st;
            primed = 1'b1;
            m_oe   = !st[ZR];
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("m_sdd_out", SDD_OUT, m_cmd);
            chk("m_sdd_oe", {7'd0, SDD_OE}, {7'd0, m_oe});
            chk("m_snd_data", M68K_SND_DATA, m_rpl);
            chk("m_nmi", {7'd0, nNMI_REQ}, {7'd0, !m_cp});
            chk("m_cmd_pend", {7'd0, CMD_PEND}, {7'd0, m_cp});
            chk("m_rpl_pend", {7'd0, RPL_PEND}, {7'd0, m_rp});
            chk("m_overrun", {7'd0, OVERRUN}, {7'd0, m_ovr});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic pulse(input logic [4:0] m);
        st = st & ~m;
        cyc(1);
        st = st | m;
        cyc(1);
    endtask

    initial begin
        cyc(3);
        chk_en = 1'b1;
        chk("rst_cmd_pend", {7'd0, CMD_PEND}, 8'd0);
        chk("rst_nmi", {7'd0, nNMI_REQ}, 8'd1);
        chk("rst_sdd_out", SDD_OUT, 8'h00);
        chk("rst_oe", {7'd0, SDD_OE}, 8'd0);
        chk("rst_overrun", {7'd0, OVERRUN}, 8'd0);
        nRESET = 1'b1;
        cyc(2);
        data = 8'h5A;
        pulse(5'b1 << WR);
        chk("wr_pend", {7'd0, CMD_PEND}, 8'd1);
        chk("wr_nmi", {7'd0, nNMI_REQ}, 8'd0);
        chk("wr_out", SDD_OUT, 8'h5A);
        st[ZR] = 1'b0;
        cyc(1);
        chk("rd_oe", {7'd0, SDD_OE}, 8'd1);
        st[ZR] = 1'b1;
        cyc(1);
        chk("rd_pend", {7'd0, CMD_PEND}, 8'd0);
        chk("rd_nmi", {7'd0, nNMI_REQ}, 8'd1);
        data = 8'h11;
        pulse(5'b1 << WR);
        data = 8'h22;
        pulse(5'b1 << WR);
        chk("ovr_out", SDD_OUT, 8'h22);
        chk("ovr_flag", {7'd0, OVERRUN}, 8'd1);
        pulse(5'b1 << CLR);
        chk("clr_ovr", {7'd0, OVERRUN}, 8'd0);
        chk("clr_out", SDD_OUT, 8'h00);
        sdd_in = 8'hA5;
        pulse(5'b1 << ZW);
        chk("zw_pend", {7'd0, RPL_PEND}, 8'd1);
        chk("zw_data", M68K_SND_DATA, 8'hA5);
        pulse(5'b1 << RD);
        chk("sndrd_pend", {7'd0, RPL_PEND}, 8'd0);
        chk("sndrd_data", M68K_SND_DATA, 8'hA5);
        data = 8'h33;
        pulse((5'b1 << WR) | (5'b1 << ZR));
        chk("wrrd_pend", {7'd0, CMD_PEND}, 8'd1);
        chk("wrrd_nmi", {7'd0, nNMI_REQ}, 8'd0);
        chk("wrrd_out", SDD_OUT, 8'h33);
        data = 8'h44;
        pulse((5'b1 << WR) | (5'b1 << CLR));
        chk("wrclr_out", SDD_OUT, 8'h44);
        chk("wrclr_ovr", {7'd0, OVERRUN}, 8'd0);
        sdd_in = 8'hC3;
        pulse((5'b1 << ZW) | (5'b1 << RD));
        chk("zwrd_pend", {7'd0, RPL_PEND}, 8'd1);
        data = 8'h55;
        st[WR] = 1'b0;
        cyc(5);
        chk("hold_out", SDD_OUT, 8'h55);
        pulse(5'b1 << ZR);
        cyc(3);
        chk("hold_once", {7'd0, CMD_PEND}, 8'd0);
        st[WR] = 1'b1;
        cyc(2);
        nRESET = 1'b0;
        st[WR] = 1'b0;
        cyc(2);
        nRESET = 1'b1;
        cyc(4);
        chk("rel_pend", {7'd0, CMD_PEND}, 8'd0);
        chk("rel_nmi", {7'd0, nNMI_REQ}, 8'd1);
        st[WR] = 1'b1;
        cyc(2);
        data = 8'h77;
        pulse(5'b1 << WR);
        chk("mid_pend", {7'd0, CMD_PEND}, 8'd1);
        nRESET = 1'b0;
        cyc(1);
        chk("mid_rst_pend", {7'd0, CMD_PEND}, 8'd0);
        chk("mid_rst_nmi", {7'd0, nNMI_REQ}, 8'd1);
        chk("mid_rst_out", SDD_OUT, 8'h00);
        chk("mid_rst_rpl", M68K_SND_DATA, 8'h00);
        nRESET = 1'b1;
        cyc(3);
        chk("mid_rel_nmi", {7'd0, nNMI_REQ}, 8'd1);
        for (int i = 0; i < 400; i++) begin
            for (int b = 0; b < 5; b++) st[b] = ($urandom_range(0, 3) != 0);
            data   = 8'($urandom_range(0, 255));
            sdd_in = 8'($urandom_range(0, 255));
            nRESET = ($urandom_range(0, 63) != 0);
            cyc(1);
        end
        st = 5'h1f;
        nRESET = 1'b1;
        cyc(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
